// File: rtl/vliw_pkg.sv
// Shared encodings, field positions, state/class types and decode helpers
// for the two-slot VLIW bundle scheduler.
package vliw_pkg;

    localparam logic [2:0]  OP_LOAD  = 3'b000;
    localparam logic [2:0]  OP_STORE = 3'b100;
    localparam logic [15:0] NOP      = 16'h0000;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 13;
    localparam int RD_HI  = 12;
    localparam int RD_LO  = 10;
    localparam int RS1_HI = 9;
    localparam int RS1_LO = 7;
    localparam int RS2_HI = 6;
    localparam int RS2_LO = 4;

    typedef enum logic [1:0] {CLS_ARITH, CLS_LOAD, CLS_STORE} cls_e;
    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_STALL} state_e;

    function automatic logic [2:0] f_op(input logic [15:0] instr);
        return instr[OP_HI:OP_LO];
    endfunction

    // rd for arith/LOAD, data register for STORE
    function automatic logic [2:0] f_rd(input logic [15:0] instr);
        return instr[RD_HI:RD_LO];
    endfunction

    function automatic logic [2:0] f_rs1(input logic [15:0] instr);
        return instr[RS1_HI:RS1_LO];
    endfunction

    function automatic logic [2:0] f_rs2(input logic [15:0] instr);
        return instr[RS2_HI:RS2_LO];
    endfunction

    function automatic cls_e instr_class(input logic [15:0] instr);
        cls_e c;
        case (f_op(instr))
            OP_LOAD:  c = CLS_LOAD;
            OP_STORE: c = CLS_STORE;
            default:  c = CLS_ARITH;
        endcase
        return c;
    endfunction

    // True when the instruction consumes register r as a source operand
    function automatic logic reads_reg(input logic [15:0] instr, input logic [2:0] r);
        logic hit;
        case (instr_class(instr))
            CLS_STORE: hit = (f_rd(instr) == r);
            CLS_ARITH: hit = (f_rs1(instr) == r) || (f_rs2(instr) == r);
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/vliw_bundle_scheduler_pair_check.sv
// Combinational pairing and load-use hazard evaluation for the held
// instruction H and the incoming instruction N.
module vliw_pair_check
    import vliw_pkg::*;
(
    input  logic [15:0] h_instr,
    input  logic [15:0] n_instr,
    input  logic [2:0]  ld_rd,
    input  logic [1:0]  stall_cnt,
    output cls_e        h_cls,
    output cls_e        n_cls,
    output logic        pairable,
    output logic        h_blocked,
    output logic        n_blocked
);

    always_comb begin
        h_cls     = instr_class(h_instr);
        n_cls     = instr_class(n_instr);
        h_blocked = (stall_cnt != 2'd0) && reads_reg(h_instr, ld_rd);
        n_blocked = (stall_cnt != 2'd0) && reads_reg(n_instr, ld_rd);
        pairable  = 1'b0;
        // Only one arith plus one memory op can share a bundle.
        if (h_cls == CLS_ARITH && n_cls == CLS_STORE) begin
            pairable = (f_rd(n_instr) != f_rd(h_instr));
        end else if (h_cls == CLS_ARITH && n_cls == CLS_LOAD) begin
            pairable = (f_rd(n_instr) != f_rd(h_instr));
        end else if (h_cls == CLS_LOAD && n_cls == CLS_ARITH) begin
            pairable = (f_rs1(n_instr) != f_rd(h_instr)) &&
                       (f_rs2(n_instr) != f_rd(h_instr)) &&
                       (f_rd(n_instr)  != f_rd(h_instr));
        end else if (h_cls == CLS_STORE && n_cls == CLS_ARITH) begin
            // the store reads its data before the arith result is written
            pairable = 1'b1;
        end
    end

endmodule

// File: rtl/vliw_bundle_scheduler.sv
// Packs a serial 16-bit instruction stream into {arith, memory} bundles,
// enforcing pairing rules and the load-use interlock behind a valid/ready output.
module vliw_bundle_scheduler
    import vliw_pkg::*;
#(
    parameter int PAIR_WAIT    = 2,
    parameter int LOAD_USE_GAP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    output logic [15:0] out_instr_a,
    output logic [15:0] out_instr_d,
    input  logic        out_ready,
    output logic        stat_paired
);

    localparam logic [3:0] WAIT_LAST = 4'(PAIR_WAIT - 1);
    localparam logic [1:0] GAP       = 2'(LOAD_USE_GAP);

    state_e      state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [1:0]  stall_cnt_q, stall_cnt_d;
    logic [2:0]  ld_rd_q, ld_rd_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] out_a_q, out_a_d;
    logic [15:0] out_d_q, out_d_d;
    logic        stat_paired_q, stat_paired_d;

    cls_e        h_cls, n_cls;
    logic        pairable, h_blocked, n_blocked;
    logic        h_valid, out_free, in_is_nop, in_ready_c, take, idle_in;
    logic        hold_valid_next, issue, paired;
    logic [15:0] slot_a, slot_d;

    vliw_pair_check u_pair_check (
        .h_instr   (hold_q),
        .n_instr   (in_instr),
        .ld_rd     (ld_rd_q),
        .stall_cnt (stall_cnt_q),
        .h_cls     (h_cls),
        .n_cls     (n_cls),
        .pairable  (pairable),
        .h_blocked (h_blocked),
        .n_blocked (n_blocked)
    );

    always_comb begin
        h_valid         = (state_q != ST_IDLE);
        out_free        = !out_valid_q || out_ready;
        in_is_nop       = (in_instr == NOP);
        in_ready_c      = !h_valid || (out_free && !h_blocked && (state_q != ST_STALL));
        take            = in_valid && in_ready_c && !in_is_nop;
        idle_in         = !in_valid || (in_is_nop && in_ready_c);
        hold_d          = hold_q;
        hold_valid_next = h_valid;
        wait_cnt_d      = wait_cnt_q;
        issue           = 1'b0;
        paired          = 1'b0;
        slot_a          = NOP;
        slot_d          = NOP;

        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    hold_d          = in_instr;
                    hold_valid_next = 1'b1;
                    wait_cnt_d      = 4'd0;
                end
            end
            ST_HOLD: begin
                if (take) begin
                    issue      = 1'b1;
                    wait_cnt_d = 4'd0;
                    if (pairable && !n_blocked) begin
                        paired          = 1'b1;
                        hold_valid_next = 1'b0;
                    end else begin
                        hold_d = in_instr;
                    end
                end else if (out_free && !h_blocked &&
                             (flush || (idle_in && wait_cnt_q == WAIT_LAST))) begin
                    issue           = 1'b1;
                    wait_cnt_d      = 4'd0;
                    hold_valid_next = 1'b0;
                end else if (idle_in && wait_cnt_q != WAIT_LAST) begin
                    // saturate so an expired wait issues as soon as the output frees
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            default: ;
        endcase

        if (issue) begin
            if (h_cls == CLS_ARITH) slot_a = hold_q;
            else                    slot_d = hold_q;
            if (paired) begin
                if (n_cls == CLS_ARITH) slot_a = in_instr;
                else                    slot_d = in_instr;
            end
        end

        ld_rd_d     = ld_rd_q;
        stall_cnt_d = (stall_cnt_q != 2'd0) ? stall_cnt_q - 2'd1 : 2'd0;
        if (issue && slot_d != NOP && f_op(slot_d) == OP_LOAD) begin
            ld_rd_d     = f_rd(slot_d);
            stall_cnt_d = GAP;
        end

        // STALL is entered whenever the instruction left holding must wait on the load
        if (!hold_valid_next) begin
            state_d = ST_IDLE;
        end else if (stall_cnt_d != 2'd0 && reads_reg(hold_d, ld_rd_d)) begin
            state_d = ST_STALL;
        end else begin
            state_d = ST_HOLD;
        end

        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_d_d     = out_d_q;
        if (issue) begin
            out_valid_d = 1'b1;
            out_a_d     = slot_a;
            out_d_d     = slot_d;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        stat_paired_d = paired;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            hold_q        <= NOP;
            wait_cnt_q    <= 4'd0;
            stall_cnt_q   <= 2'd0;
            ld_rd_q       <= 3'd0;
            out_valid_q   <= 1'b0;
            out_a_q       <= NOP;
            out_d_q       <= NOP;
            stat_paired_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            ld_rd_q       <= ld_rd_d;
            out_valid_q   <= out_valid_d;
            out_a_q       <= out_a_d;
            out_d_q       <= out_d_d;
            stat_paired_q <= stat_paired_d;
        end
    end

    assign in_ready    = in_ready_c;
    assign out_valid   = out_valid_q;
    assign out_instr_a = out_a_q;
    assign out_instr_d = out_d_q;
    assign stat_paired = stat_paired_q;

endmodule

// File: tb/tb_vliw_bundle_scheduler.sv
// Directed self-checking bench for vliw_bundle_scheduler (PAIR_WAIT=2, LOAD_USE_GAP=1).
module tb_vliw_bundle_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [15:0] out_instr_a;
    logic [15:0] out_instr_d;
    logic        out_ready;
    logic        stat_paired;

    int tests = 0;
    int fails = 0;
    logic [31:0] acked[$];

    always #5 clk = ~clk;

    vliw_bundle_scheduler #(.PAIR_WAIT(2), .LOAD_USE_GAP(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_instr_a (out_instr_a),
        .out_instr_d (out_instr_d),
        .out_ready   (out_ready),
        .stat_paired (stat_paired)
    );

    // record every bundle handed over to decode
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready)
            acked.push_back({out_instr_a, out_instr_d});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] instr);
        in_valid = v;
        in_instr = instr;
    endtask

    task automatic chk_bundle(input string tag, input logic [15:0] a, input logic [15:0] d,
                              input logic sp);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_a"}, {16'd0, out_instr_a}, {16'd0, a});
        chk({tag, "_d"}, {16'd0, out_instr_d}, {16'd0, d});
        chk({tag, "_paired"}, {31'd0, stat_paired}, {31'd0, sp});
        $display("[TB] %s: bundle a=%h d=%h paired=%0d", tag, out_instr_a, out_instr_d, stat_paired);
    endtask

    initial begin
        int qs;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 16'h0000);
        tick(); tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_a", {16'd0, out_instr_a}, 32'd0);
        chk("rst_d", {16'd0, out_instr_d}, 32'd0);
        chk("rst_paired", {31'd0, stat_paired}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // ADD r1,r2,r3 then LOAD r4: one paired bundle
        drive(1'b1, 16'hA530); tick();
        drive(1'b1, 16'h1005); #1;
        chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b0, 16'h0000);
        chk_bundle("t1_pair", 16'hA530, 16'h1005, 1'b1);
        tick();
        chk("t1_drop_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_drop_paired", {31'd0, stat_paired}, 32'd0);

        // LOAD r2 then consumer ADD: load alone, stall, then add alone
        drive(1'b1, 16'h0805); tick();
        drive(1'b1, 16'hA530); tick();
        drive(1'b0, 16'h0000); #1;
        chk_bundle("t2_load", 16'h0000, 16'h0805, 1'b0);
        chk("t2_stall_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        for (int i = 0; i < 8 && !out_valid; i++) tick();
        chk_bundle("t2_use", 16'hA530, 16'h0000, 1'b0);
        tick();

        // ADD r1 then STORE r1: dependent, two singles in order
        drive(1'b1, 16'hA530); tick();
        drive(1'b1, 16'h8406); tick();
        drive(1'b0, 16'h0000);
        chk_bundle("t3_add", 16'hA530, 16'h0000, 1'b0);
        tick();
        chk("t3_gap_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk_bundle("t3_store", 16'h0000, 16'h8406, 1'b0);
        tick();

        // STORE r1 then ADD writing r1: pairable, slots placed by class
        drive(1'b1, 16'h8406); tick();
        drive(1'b1, 16'hA530); tick();
        drive(1'b0, 16'h0000);
        chk_bundle("t3b_pair", 16'hA530, 16'h8406, 1'b1);
        tick();

        // Single ADD, wait timeout issues exactly 2 cycles after acceptance
        drive(1'b1, 16'hA530); tick();
        drive(1'b0, 16'h0000); tick();
        chk("t4_wait1_valid", {31'd0, out_valid}, 32'd0);
        tick();
        chk_bundle("t4_timeout", 16'hA530, 16'h0000, 1'b0);
        tick();

        // flush in the first idle cycle issues 1 cycle after acceptance
        drive(1'b1, 16'hA530); tick();
        drive(1'b0, 16'h0000); flush = 1'b1; tick();
        flush = 1'b0;
        chk_bundle("t4_flush", 16'hA530, 16'h0000, 1'b0);
        tick();
        flush = 1'b1; tick(); flush = 1'b0;
        chk("t4_flush_idle", {31'd0, out_valid}, 32'd0);

        // NOP is accepted and discarded
        drive(1'b1, 16'h0000); #1;
        chk("t_nop_in_ready", {31'd0, in_ready}, 32'd1);
        tick(); drive(1'b0, 16'h0000);
        tick(); tick(); tick();
        chk("t_nop_no_issue", {31'd0, out_valid}, 32'd0);

        // ADD r1 then LOAD r1 (WAW): two singles
        drive(1'b1, 16'hA530); tick();
        drive(1'b1, 16'h0405); tick();
        drive(1'b0, 16'h0000);
        chk_bundle("t_waw_add", 16'hA530, 16'h0000, 1'b0);
        tick(); tick();
        chk_bundle("t_waw_load", 16'h0000, 16'h0405, 1'b0);
        tick(); tick();

        // back-pressure: bundle held stable, nothing lost or duplicated
        qs = acked.size();
        out_ready = 1'b0;
        drive(1'b1, 16'hA530); tick();
        drive(1'b1, 16'h8406); tick();
        drive(1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("t5_hold_a", {16'd0, out_instr_a}, 32'h0000A530);
            chk("t5_hold_d", {16'd0, out_instr_d}, 32'd0);
            chk("t5_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        chk("t5_no_ack", acked.size(), qs);
        out_ready = 1'b1; tick();
        chk_bundle("t5_next", 16'h0000, 16'h8406, 1'b0);
        tick();
        chk("t5_count", acked.size(), qs + 2);
        if (acked.size() == qs + 2) begin
            chk("t5_first", acked[qs], {16'hA530, 16'h0000});
            chk("t5_second", acked[qs + 1], {16'h0000, 16'h8406});
        end
        chk("t5_drop_valid", {31'd0, out_valid}, 32'd0);

        // reset with a held instruction and a pending bundle
        out_ready = 1'b0;
        drive(1'b1, 16'hA530); tick();
        drive(1'b1, 16'h8406); tick();
        drive(1'b0, 16'h0000);
        rst_n = 1'b0; tick();
        chk("t6_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_a", {16'd0, out_instr_a}, 32'd0);
        chk("t6_d", {16'd0, out_instr_d}, 32'd0);
        chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1; out_ready = 1'b1;
        tick(); tick(); tick();
        chk("t6_no_stale", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 16'hA530); tick();
        drive(1'b1, 16'h1005); tick();
        drive(1'b0, 16'h0000);
        chk_bundle("t6_fresh", 16'hA530, 16'h1005, 1'b1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vliw_bundle_scheduler.md
Name: vliw_bundle_scheduler

Overview:
- Sits between instruction fetch and the VLIW decode/control stage.
- Takes a serial stream of 16-bit instructions and packs them into two-slot bundles: slot A (arithmetic) and slot D (load/store).
- Enforces intra-bundle dependency rules and the load-use interlock, then presents each bundle through a valid/ready handshake.
- An empty slot is always filled with the NOP encoding 16'h0000.

Parameters:
- PAIR_WAIT, 2: consecutive idle input cycles a held instruction waits for a partner before issuing alone (legal range 1..15).
- LOAD_USE_GAP, 1: number of bundles/cycles after a LOAD issue during which a consumer of the load destination register may not issue (legal range 0..3).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  fetch instruction valid
- in_instr  in  16  fetch instruction
- in_ready  out  1  scheduler accepts in_instr this cycle
- flush  in  1  force the held instruction to issue alone at the next opportunity
- out_valid  out  1  bundle valid
- out_instr_a  out  16  arithmetic slot (Instr1 of decode)
- out_instr_d  out  16  memory slot (Instr2 of decode)
- out_ready  in  1  decode accepts bundle
- stat_paired  out  1  one-cycle pulse when an issued bundle carries two instructions

Behaviour:
- Encoding is opcode [15:13]: 000 LOAD, 100 STORE, 001/010/011/101/110/111 arithmetic.
  - Arith fields: rd [12:10], rs1 [9:7], rs2 [6:4].
  - LOAD fields: rd [12:10], addr [9:0].
  - STORE fields: data reg [12:10], addr [9:0].
  - 16'h0000 is NOP: it is accepted (normal in_ready) and discarded, never held.
- Reset (rst_n low at a clk edge):
  - out_valid=0, out_instr_a=out_instr_d=16'h0000, stat_paired=0.
  - Hold register empty, wait_cnt=0, stall_cnt=0, state IDLE.
  - Mid-operation reset discards the held instruction and any un-acked bundle.
- State machine:
  - IDLE (hold empty):
    - A non-NOP accepted input is loaded into the hold register; go to HOLD.
    - No issue happens from IDLE.
  - HOLD (hold valid H, issue possible when out_free = !out_valid || out_ready):
    - in_valid, N pairable with H, both hazard-clear → issue {H,N}, hold empty, go to IDLE; stat_paired=1.
    - in_valid, not pairable or N hazard-blocked, H hazard-clear → issue H alone, N becomes the new H, stay HOLD.
    - in_valid low → wait_cnt increments. On the PAIR_WAIT-th consecutive idle cycle, or when flush=1, issue H alone and go to IDLE.
    - wait_cnt clears on every issue.
  - STALL (H reads ld_rd while stall_cnt≠0):
    - in_ready=0, no issue.
    - stall_cnt decrements each cycle; return to HOLD when it reaches 0.
- Pairable means H and N are of different classes, subject to these rules:
  - Arith then STORE with data reg == arith rd: not pairable.
  - Arith then LOAD with rd == arith rd: not pairable (WAW).
  - LOAD then arith reading or writing the load rd: not pairable.
  - STORE then arith writing the store data reg: pairable (reads precede writes).
- Load-use interlock:
  - Issuing a bundle with a LOAD captures ld_rd and sets stall_cnt=LOAD_USE_GAP.
  - An instruction that reads ld_rd (arith rs1/rs2, STORE data reg) is hazard-blocked while stall_cnt≠0.
  - stall_cnt decrements every cycle, saturating at 0.
- in_ready = !hold_valid || (out_free && H hazard-clear && !in STALL). flush has no effect in IDLE.
- Output timing:
  - Outputs are registered and update only on an issue edge.
  - While out_valid && !out_ready, all outputs hold stable.
  - out_valid drops on the ack edge if no new issue occurs.
  - stat_paired is high only in the cycle following a paired issue edge.
- Latency: an instruction accepted at edge k issues no earlier than edge k+1, and appears on outputs after that edge.
- Slot placement: an arithmetic instruction always goes to slot A and a memory instruction always to slot D, regardless of arrival order.

Decomposition:
- vliw_pkg holds the opcode constants (OP_LOAD, OP_STORE, arith set), field bit positions, NOP=16'h0000, and state encoding IDLE/HOLD/STALL.
- Sub-module vliw_pair_check (combinational) computes class, pairable, and hazard-blocked from H, N, ld_rd, and stall_cnt.

Test Plan:
- ADD r1,r2,r3 (16'hA530) then LOAD r4 (16'h1005) back-to-back, out_ready=1 → one bundle a=A530, d=1005, stat_paired=1.
- LOAD r2 (16'h0805) then A530 → bundle a=0000, d=0805, then after 1 extra stall cycle bundle a=A530, d=0000. in_ready must be low during the stall.
- ADD r1 (A530) then STORE r1 (16'h8406) → two single bundles in order A530 then 8406, stat_paired never asserted.
- Single A530 then in_valid low, PAIR_WAIT=2 → bundle a=A530, d=0000 appears exactly 2 cycles after acceptance. With flush=1 asserted in the first idle cycle, it issues 1 cycle after acceptance.
- Hold out_ready=0 for 5 cycles with a bundle pending → outputs stable, in_ready low once H is held and blocked, no bundle lost or duplicated.
- Assert rst_n=0 with a held instruction and a pending bundle → next cycle out_valid=0, slots 0000, and a following stream is scheduled as if fresh.
